v_dmem_responder: RTL and testbench
===================================

# v_dmem_responder

Memory-side responder for the vector coprocessor's four-port data-memory bus. It accepts one vector load or store request per transaction across ports 0–3 and stores data in four single-ported word banks. It resolves bank conflicts by serializing them over successive rounds, then returns load data to the coprocessor with a completion pulse. It sits between the coprocessor's LSU outputs (`is_vltype`, `is_vstype`, `dm_v_write`, `data_addr0..3`, `v_store_data_0..3`) and its `v_load_data_0..3` inputs.

## Interface
- `ADDR_BITS`, default `` `DATAMEM_BITS ``: word-address width; each bank holds 2^(ADDR_BITS-2) words.
- `DATA_WIDTH`, default `` `DATAMEM_WIDTH ``: word width.

- `clk` in 1: the single clock; everything is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `is_vltype` in 1: load request qualifier.
- `is_vstype` in 1: store request qualifier.
- `dm_v_write` in 1: store write enable; a store request is `is_vstype && dm_v_write`.
- `data_addr0..3` in ADDR_BITS each: per-port word address.
- `v_store_data_0..3` in DATA_WIDTH each: per-port store data.
- `v_load_data_0..3` out DATA_WIDTH each: per-port load data, registered.
- `rd_valid` out 1: one-cycle pulse; load data is updated and valid.
- `wr_done` out 1: one-cycle pulse; all store words have been committed.
- `busy` out 1: a transaction is in progress; new requests are ignored.
- `protocol_err` out 1: sticky flag, cleared only by `rst`.

## Operation
- **Bank mapping:** bank = `addr[1:0]`; row = `addr[ADDR_BITS-1:2]`.
- **States:** IDLE, SERVE, RESP.
- **IDLE:** at an edge with `busy=0`, a read (`is_vltype`) or a write (`is_vstype && dm_v_write`) is accepted.
  - All four addresses, all four data words and the op are latched.
  - The pending mask is set to 4'b1111, and the state moves to SERVE.
  - `is_vstype` without `dm_v_write` is not a request.
- **Both qualifiers high in IDLE:** no request is accepted, `protocol_err` is set to 1, and the state stays IDLE.
- **SERVE:** each cycle forms one round, computed combinationally from the pending mask.
  - Per bank, grant the lowest-index pending port mapped to that bank.
  - Read only: also grant every other pending port whose address equals that granted port's address (merge). Writes are never merged.
  - Granted ports are committed at the edge and cleared from the pending mask.
  - Write rounds write the latched data into the bank. Read rounds capture the bank word into that port's staging register.
  - When the mask becomes 0 at an edge, the state moves to RESP.
- **Same-address writes:** ports are served in ascending index order, so the highest-index port's data remains.
- **RESP (one cycle):**
  - Read: staging registers are copied to `v_load_data_*` at the edge entering RESP, and `rd_valid=1`.
  - Write: `wr_done=1`.
  - `busy=0` during RESP, so a new request can be accepted at the edge leaving RESP. The state then returns to IDLE, or moves to SERVE if a request is accepted.
- **Load data hold:** `v_load_data_*` holds its value until the next read completes. A write does not change it.
- **Round count:** N = maximum number of distinct pending conflict groups on any bank, 1 ≤ N ≤ 4.
- **Reset:** at an edge with `rst=1`:
  - State goes to IDLE and the pending mask is cleared.
  - `v_load_data_*`, `rd_valid`, `wr_done`, `busy` and `protocol_err` all go to 0.
  - Bank contents are not cleared.
  - An in-flight write may be partially committed; its completed rounds persist.

## Timing
- Accept edge E0. Rounds commit at edges E1..EN.
- `busy=1` from after E0 until EN. RESP is the cycle between EN and EN+1, where `rd_valid`/`wr_done` is high.
- Conflict-free latency: the response is sampled at E2. Worst case, four rounds: sampled at E5.
- The requester holds addresses and data at least until the accept edge. Values after E0 are ignored.
- Back-to-back throughput: one transaction per N+1 cycles.

## Test plan
- **Reset:** assert `rst` for 2 cycles with a request present → all outputs 0, no accept. Deassert → `busy=0`.
- **Unit stride:** write 0xA0,0xA1,0xA2,0xA3 to addresses 0x10..0x13 (1 round; `wr_done` sampled at E2), then read the same addresses → `rd_valid` sampled at E2 with `v_load_data_0..3` = 0xA0..0xA3.
- **Stride 4:** read addresses 0x0,0x4,0x8,0xC, all on bank 0 → `busy` for 4 cycles, `rd_valid` at E5, all four words correct.
- **Stride 0 merge:** read address 0x20 on all ports (memory holds 0x55) → 1 round; `rd_valid` at E2; all ports read 0x55.
- **Write conflict:** ports 0–3 write 0x1,0x2,0x3,0x4 to address 0x30 → 4 rounds, `wr_done` at E5. A subsequent read returns 0x4.
- **Protocol error and mid-transaction reset:**
  - `is_vltype=is_vstype=1` in IDLE → `protocol_err=1` and stays 1, `busy=0`.
  - Start a stride-4 read, then assert `rst` at E2 → IDLE, `rd_valid` never pulses, `protocol_err=0`.

Source files
------------

// File: rtl/v_dmem_responder.sv
// Four-port vector data-memory responder with four word banks.
// Ports: clk/rst, vector load/store request, per-port addr/data in, load data, status out.
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 8
`endif
`ifndef DATAMEM_WIDTH
`define DATAMEM_WIDTH 32
`endif

module v_dmem_responder #(
  parameter int ADDR_BITS  = `DATAMEM_BITS,
  parameter int DATA_WIDTH = `DATAMEM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  is_vltype,
  input  logic                  is_vstype,
  input  logic                  dm_v_write,
  input  logic [ADDR_BITS-1:0]  data_addr0,
  input  logic [ADDR_BITS-1:0]  data_addr1,
  input  logic [ADDR_BITS-1:0]  data_addr2,
  input  logic [ADDR_BITS-1:0]  data_addr3,
  input  logic [DATA_WIDTH-1:0] v_store_data_0,
  input  logic [DATA_WIDTH-1:0] v_store_data_1,
  input  logic [DATA_WIDTH-1:0] v_store_data_2,
  input  logic [DATA_WIDTH-1:0] v_store_data_3,
  output logic [DATA_WIDTH-1:0] v_load_data_0,
  output logic [DATA_WIDTH-1:0] v_load_data_1,
  output logic [DATA_WIDTH-1:0] v_load_data_2,
  output logic [DATA_WIDTH-1:0] v_load_data_3,
  output logic                  rd_valid,
  output logic                  wr_done,
  output logic                  busy,
  output logic                  protocol_err
);

  localparam int ROWB  = ADDR_BITS - 2;
  localparam int DEPTH = 1 << ROWB;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_BITS-1:0]  addr_in [4];
  logic [DATA_WIDTH-1:0] wdat_in [4];
  logic [ADDR_BITS-1:0]  addr_q  [4];
  logic [DATA_WIDTH-1:0] wdat_q  [4];
  logic [DATA_WIDTH-1:0] stage_q [4];
  logic [DATA_WIDTH-1:0] stage_d [4];
  logic [DATA_WIDTH-1:0] ld_q    [4];
  logic                  op_wr_q;
  logic [3:0]            pend_q;
  logic [3:0]            pend_nxt;
  logic                  perr_q;

  logic [DATA_WIDTH-1:0] mem [4][DEPTH];

  logic [1:0]            lead     [4];
  logic [3:0]            bank_hit;
  logic [ROWB-1:0]       brow     [4];
  logic [DATA_WIDTH-1:0] bwd      [4];
  logic [DATA_WIDTH-1:0] brd      [4];
  logic [3:0]            gnt;

  logic rd_req, wr_req, both_req, take, last_rnd;

  assign addr_in[0] = data_addr0;
  assign addr_in[1] = data_addr1;
  assign addr_in[2] = data_addr2;
  assign addr_in[3] = data_addr3;
  assign wdat_in[0] = v_store_data_0;
  assign wdat_in[1] = v_store_data_1;
  assign wdat_in[2] = v_store_data_2;
  assign wdat_in[3] = v_store_data_3;

  assign busy     = (state_q == SERVE);
  assign rd_req   = is_vltype & ~is_vstype;
  assign wr_req   = is_vstype & dm_v_write & ~is_vltype;
  assign both_req = is_vltype & is_vstype;
  assign take     = ~busy & (rd_req | wr_req);

  // Lowest pending port per bank leads the round; scan
  // downward so the lowest index is assigned last.
  always_comb begin
    bank_hit = '0;
    for (int b = 0; b < 4; b++) begin
      lead[b] = '0;
      for (int p = 3; p >= 0; p--) begin
        if (pend_q[p] && addr_q[p][1:0] == 2'(b)) begin
          bank_hit[b] = 1'b1;
          lead[b]     = 2'(p);
        end
      end
    end
  end

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      brow[b] = addr_q[lead[b]][ADDR_BITS-1:2];
      bwd[b]  = wdat_q[lead[b]];
      brd[b]  = mem[b][brow[b]];
    end
  end

  // Reads merge every pending port sharing the leader's
  // address; writes take only the leader.
  always_comb begin
    gnt = '0;
    for (int p = 0; p < 4; p++) begin
      stage_d[p] = stage_q[p];
      if (pend_q[p]) begin
        if (op_wr_q)
          gnt[p] = (lead[addr_q[p][1:0]] == 2'(p));
        else
          gnt[p] = (addr_q[p] == addr_q[lead[addr_q[p][1:0]]]);
      end
      if (gnt[p])
        stage_d[p] = brd[addr_q[p][1:0]];
    end
  end

  assign pend_nxt = pend_q & ~gnt;
  assign last_rnd = busy && (pend_nxt == 4'b0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take) state_d = SERVE;
      SERVE:   if (pend_nxt == 4'b0) state_d = RESP;
      RESP:    state_d = take ? SERVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      perr_q  <= 1'b0;
      for (int p = 0; p < 4; p++) ld_q[p] <= '0;
    end else begin
      state_q <= state_d;
      if (take)
        pend_q <= 4'hF;
      else if (busy)
        pend_q <= pend_nxt;
      if (~busy && both_req)
        perr_q <= 1'b1;
      if (last_rnd && !op_wr_q)
        ld_q <= stage_d;
    end
  end

  always_ff @(posedge clk) begin
    stage_q <= stage_d;
    if (take) begin
      addr_q  <= addr_in;
      wdat_q  <= wdat_in;
      op_wr_q <= wr_req;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (busy && op_wr_q && bank_hit[b])
        mem[b][brow[b]] <= bwd[b];
    end
  end

  assign rd_valid     = (state_q == RESP) && !op_wr_q;
  assign wr_done      = (state_q == RESP) && op_wr_q;
  assign protocol_err = perr_q;

  assign v_load_data_0 = ld_q[0];
  assign v_load_data_1 = ld_q[1];
  assign v_load_data_2 = ld_q[2];
  assign v_load_data_3 = ld_q[3];

endmodule

// File: tb/tb_v_dmem_responder.sv
// Bench for v_dmem_responder: flat-memory reference model,
// directed scenarios plus randomized loads/stores.
module tb_v_dmem_responder;
  localparam int AB = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst, is_vltype, is_vstype, dm_v_write;
  logic [AB-1:0] data_addr0, data_addr1, data_addr2, data_addr3;
  logic [DW-1:0] v_store_data_0, v_store_data_1;
  logic [DW-1:0] v_store_data_2, v_store_data_3;
  logic [DW-1:0] v_load_data_0, v_load_data_1;
  logic [DW-1:0] v_load_data_2, v_load_data_3;
  logic rd_valid, wr_done, busy, protocol_err;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] model [256];
  logic [DW-1:0] last_ld [4];
  logic [DW-1:0] ld [4];

  assign ld[0] = v_load_data_0;
  assign ld[1] = v_load_data_1;
  assign ld[2] = v_load_data_2;
  assign ld[3] = v_load_data_3;

  v_dmem_responder #(.ADDR_BITS(AB), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .is_vltype(is_vltype), .is_vstype(is_vstype),
    .dm_v_write(dm_v_write),
    .data_addr0(data_addr0), .data_addr1(data_addr1),
    .data_addr2(data_addr2), .data_addr3(data_addr3),
    .v_store_data_0(v_store_data_0),
    .v_store_data_1(v_store_data_1),
    .v_store_data_2(v_store_data_2),
    .v_store_data_3(v_store_data_3),
    .v_load_data_0(v_load_data_0),
    .v_load_data_1(v_load_data_1),
    .v_load_data_2(v_load_data_2),
    .v_load_data_3(v_load_data_3),
    .rd_valid(rd_valid), .wr_done(wr_done),
    .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit vl, input bit vs, input bit we,
                       input logic [3:0][AB-1:0] a,
                       input logic [3:0][DW-1:0] d);
    is_vltype = vl;
    is_vstype = vs;
    dm_v_write = we;
    data_addr0 = a[0]; data_addr1 = a[1];
    data_addr2 = a[2]; data_addr3 = a[3];
    v_store_data_0 = d[0]; v_store_data_1 = d[1];
    v_store_data_2 = d[2]; v_store_data_3 = d[3];
  endtask

  task automatic drive_junk();
    logic [3:0][AB-1:0] a;
    logic [3:0][DW-1:0] d;
    for (int p = 0; p < 4; p++) begin
      a[p] = AB'($urandom);
      d[p] = $urandom;
    end
    drive(1'b0, 1'b0, 1'b0, a, d);
  endtask

  // Rounds = worst bank's number of separate accesses:
  // every write port counts, reads count distinct addresses.
  function automatic int exp_rounds(input bit wr,
                                    input logic [3:0][AB-1:0] a);
    int n;
    int c;
    bit seen;
    n = 0;
    for (int b = 0; b < 4; b++) begin
      c = 0;
      for (int p = 0; p < 4; p++) begin
        if (int'(a[p] % 4) == b) begin
          seen = 1'b0;
          if (!wr)
            for (int q = 0; q < p; q++)
              if (a[q] == a[p]) seen = 1'b1;
          if (!seen) c++;
        end
      end
      if (c > n) n = c;
    end
    return n;
  endfunction

  task automatic do_txn(input string name, input bit wr,
                        input logic [3:0][AB-1:0] a,
                        input logic [3:0][DW-1:0] d);
    int n;
    int got;
    logic [DW-1:0] exp;
    logic [2:0] st, st_exp;
    n = exp_rounds(wr, a);
    got = 0;
    @(negedge clk);
    drive(!wr, wr, wr, a, d);
    @(posedge clk); #1;
    drive_junk();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
    end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (rd_valid === 1'b1 || wr_done === 1'b1) begin
        got = k;
        break;
      end
    end
    total++;
    if (got != n) begin
      bad++;
      $display("FAIL %s latency: got E%0d want E%0d", name, got, n);
    end
    if (wr)
      for (int p = 0; p < 4; p++) model[a[p]] = d[p];
    st = {rd_valid, wr_done, busy};
    st_exp = wr ? 3'b010 : 3'b100;
    total++;
    if (st !== st_exp) begin
      bad++;
      $display("FAIL %s resp_flags{rd,wr,busy}: got %b want %b",
               name, st, st_exp);
    end
    for (int p = 0; p < 4; p++) begin
      exp = wr ? last_ld[p] : model[a[p]];
      total++;
      if (ld[p] !== exp) begin
        bad++;
        $display("FAIL %s load_data%0d: got %h want %h",
                 name, p, ld[p], exp);
      end
      if (!wr) last_ld[p] = exp;
    end
  endtask

  task automatic test_reset();
    logic [3:0][AB-1:0] a;
    logic [3:0][DW-1:0] d;
    for (int p = 0; p < 4; p++) begin
      a[p] = AB'(p);
      d[p] = 32'h0;
    end
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, a, d);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0 || rd_valid !== 1'b0 || wr_done !== 1'b0 ||
          protocol_err !== 1'b0 || ld[0] !== 0 || ld[1] !== 0 ||
          ld[2] !== 0 || ld[3] !== 0) begin
        bad++;
        $display("FAIL reset_outputs: got busy=%b rd=%b wr=%b perr=%b ld0=%h want all 0",
                 busy, rd_valid, wr_done, protocol_err, ld[0]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    drive_junk();
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_busy: got %b want 0", busy);
    end
    for (int p = 0; p < 4; p++) last_ld[p] = '0;
  endtask

  task automatic test_fill();
    logic [3:0][AB-1:0] a;
    logic [3:0][DW-1:0] d;
    for (int i = 0; i < 64; i++) begin
      for (int p = 0; p < 4; p++) begin
        a[p] = AB'(4 * i + p);
        d[p] = $urandom;
      end
      do_txn("fill", 1'b1, a, d);
    end
  endtask

  task automatic test_unit_stride();
    logic [3:0][AB-1:0] a;
    logic [3:0][DW-1:0] d;
    for (int p = 0; p < 4; p++) begin
      a[p] = AB'(8'h10 + p);
      d[p] = 32'hA0 + p;
    end
    do_txn("unit_wr", 1'b1, a, d);
    do_txn("unit_rd", 1'b0, a, d);
  endtask

  task automatic test_stride4();
    logic [3:0][AB-1:0] a;
    logic [3:0][DW-1:0] d;
    for (int p = 0; p < 4; p++) begin
      a[p] = AB'(4 * p);
      d[p] = '0;
    end
    do_txn("stride4_rd", 1'b0, a, d);
  endtask

  task automatic test_merge();
    logic [3:0][AB-1:0] a;
    logic [3:0][DW-1:0] d;
    for (int p = 0; p < 4; p++) begin
      a[p] = 8'h20;
      d[p] = 32'h55;
    end
    do_txn("merge_wr", 1'b1, a, d);
    do_txn("merge_rd", 1'b0, a, d);
  endtask

  task automatic test_write_conflict();
    logic [3:0][AB-1:0] a;
    logic [3:0][DW-1:0] d;
    for (int p = 0; p < 4; p++) begin
      a[p] = 8'h30;
      d[p] = 32'(p + 1);
    end
    do_txn("conflict_wr", 1'b1, a, d);
    do_txn("conflict_rd", 1'b0, a, d);
    total++;
    if (ld[0] !== 32'h4) begin
      bad++;
      $display("FAIL conflict_last_wins: got %h want 4", ld[0]);
    end
  endtask

  task automatic test_random();
    logic [3:0][AB-1:0] a;
    logic [3:0][DW-1:0] d;
    bit wr;
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom);
      for (int p = 0; p < 4; p++) begin
        // narrow address pool to provoke conflicts and merges
        a[p] = ($urandom_range(1) == 1) ? AB'($urandom_range(15))
                                        : AB'($urandom);
        d[p] = $urandom;
      end
      do_txn("random", wr, a, d);
    end
  endtask

  task automatic test_protocol_err();
    logic [3:0][AB-1:0] a;
    logic [3:0][DW-1:0] d;
    for (int p = 0; p < 4; p++) begin
      a[p] = AB'(p);
      d[p] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, a, d);
    @(posedge clk); #1;
    drive_junk();
    total++;
    if (protocol_err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL perr_set: got perr=%b busy=%b want 1 0",
               protocol_err, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (protocol_err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL perr_sticky: got perr=%b busy=%b want 1 0",
               protocol_err, busy);
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0][AB-1:0] a;
    logic [3:0][DW-1:0] d;
    bit seen;
    for (int p = 0; p < 4; p++) begin
      a[p] = AB'(4 * p);
      d[p] = '0;
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, a, d);
    @(posedge clk); #1;
    drive_junk();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 ||
        protocol_err !== 1'b0 || ld[0] !== 0) begin
      bad++;
      $display("FAIL midreset_state: got busy=%b rd=%b perr=%b ld0=%h want 0 0 0 0",
               busy, rd_valid, protocol_err, ld[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (rd_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL midreset_no_resp: got activity want none");
    end
    for (int p = 0; p < 4; p++) last_ld[p] = '0;
    do_txn("post_reset_rd", 1'b0, a, d);
  endtask

  initial begin
    rst = 1'b1;
    drive_junk();
    test_reset();
    test_fill();
    test_unit_stride();
    test_stride4();
    test_merge();
    test_write_conflict();
    test_random();
    test_protocol_err();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
